// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/grant bundle between requesters and the round-robin mux arbiter
interface mux_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic [3:0] hold_cnt;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  valid,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output valid,
    output hold_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbiter for the shared 8:1 result mux select
// Optional macro ARB_HOLD_LIMIT_EN enables forced rotation after MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   arb
);

`ifdef ARB_HOLD_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [3:0] hold_q, hold_d;

  logic [7:0] others;
  logic       owner_req;
  logic       expire;
  logic [3:0] pick_req;
  logic [3:0] pick_oth;
  logic       do_grant;
  logic [2:0] win;

  // {found, index}: first set bit scanning start, start+1, ... with wrap-around.
  function automatic logic [3:0] pick(input logic [7:0] cand, input logic [2:0] start);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (cand[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign owner_req = arb.req[sel_q];
  assign others    = arb.req & ~(8'b1 << sel_q);
  assign expire    = LIMIT_EN && (hold_q == HOLD_LAST) && (others != 8'b0);
  assign pick_req  = pick(arb.req, ptr_q);
  assign pick_oth  = pick(others, ptr_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    win      = 3'd0;
    case (state_q)
      IDLE: begin
        if (pick_req[3]) begin
          do_grant = 1'b1;
          win      = pick_req[2:0];
        end
      end
      OWN: begin
        if (!owner_req) begin
          if (pick_oth[3]) begin
            do_grant = 1'b1;
            win      = pick_oth[2:0];
          end else begin
            // sel deliberately keeps the last owner so the mux lane stays put
            state_d = IDLE;
            gnt_d   = 8'b0;
            valid_d = 1'b0;
            hold_d  = 4'd0;
          end
        end else if (expire) begin
          do_grant = 1'b1;
          win      = pick_oth[2:0];
        end else if (hold_q != 4'hF) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_grant) begin
      state_d = OWN;
      gnt_d   = 8'b1 << win;
      sel_d   = win;
      valid_d = 1'b1;
      hold_d  = 4'd0;
      ptr_d   = win + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      gnt_q   <= 8'b0;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign arb.gnt      = gnt_q;
  assign arb.sel      = sel_q;
  assign arb.valid    = valid_q;
  assign arb.hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - randomized and directed bench for mux_rr_arbiter against a behavioural model
module tb_mux_rr_arbiter;
  localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_LIMIT = 1'b1;
`else
  localparam bit HOLD_LIMIT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int owner;
    int ptr;
    int hold;
    int sel;
  } mstate_t;

  mstate_t m = '{owner: -1, ptr: 0, hold: 0, sel: 0};

  function automatic int winner(logic [7:0] r, int ptr);
    for (int k = 0; k < 8; k++) begin
      if (r[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  function automatic mstate_t granted(int w);
    mstate_t n;
    n.owner = w;
    n.sel   = w;
    n.ptr   = (w + 1) % 8;
    n.hold  = 0;
    return n;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [7:0] r);
    mstate_t    n;
    logic [7:0] oth;
    int         w;
    n = s;
    if (s.owner < 0) begin
      w = winner(r, s.ptr);
      if (w >= 0) n = granted(w);
    end else begin
      oth = r;
      oth[s.owner] = 1'b0;
      if (!r[s.owner]) begin
        w = winner(oth, s.ptr);
        if (w >= 0) n = granted(w);
        else begin
          n.owner = -1;
          n.hold  = 0;
        end
      end else if (HOLD_LIMIT && s.hold == MAX_HOLD - 1 && oth != 8'b0) begin
        n = granted(winner(oth, s.ptr));
      end else begin
        n.hold = (s.hold < 15) ? s.hold + 1 : 15;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: -1, ptr: 0, hold: 0, sel: 0};
    else        m <= step(m, bus.req);
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_gnt",   32'(bus.gnt),      (m.owner < 0) ? 32'h0 : 32'(1 << m.owner));
    chk("model_sel",   32'(bus.sel),      32'(m.sel));
    chk("model_valid", 32'(bus.valid),    (m.owner < 0) ? 32'h0 : 32'h1);
    chk("model_hold",  32'(bus.hold_cnt), 32'(m.hold));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] r;

  initial begin
    checks = 0;
    errors = 0;
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    repeat (3) tick();
    chk("reset_gnt",   32'(bus.gnt),   32'h00);
    chk("reset_sel",   32'(bus.sel),   32'h0);
    chk("reset_valid", 32'(bus.valid), 32'h0);
    chk("reset_hold",  32'(bus.hold_cnt), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("first_gnt",   32'(bus.gnt),   32'h01);
    chk("first_sel",   32'(bus.sel),   32'h0);
    chk("first_valid", 32'(bus.valid), 32'h1);

    for (int k = 1; k <= 8; k++) begin
      bus.req = 8'hFF & ~bus.gnt;
      tick();
      chk("rotate_sel", 32'(bus.sel), 32'(k % 8));
    end

    bus.req = 8'h40;
    tick();
    chk("wrap_pre_gnt", 32'(bus.gnt), 32'h40);
    bus.req = 8'h05;
    tick();
    chk("wrap_gnt", 32'(bus.gnt), 32'h01);
    chk("wrap_sel", 32'(bus.sel), 32'h0);

    bus.req = 8'h00;
    tick();
    bus.req = 8'h08;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_ret_gnt",  32'(bus.gnt),      32'h08);
      chk("idle_ret_hold", 32'(bus.hold_cnt), 32'(c));
    end
    bus.req = 8'h00;
    tick();
    chk("idle_gnt",   32'(bus.gnt),   32'h00);
    chk("idle_valid", 32'(bus.valid), 32'h0);
    chk("idle_sel",   32'(bus.sel),   32'h3);

    bus.req = 8'h03;
`ifdef ARB_HOLD_LIMIT_EN
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("limit_gnt",  32'(bus.gnt),      ((c / 4) % 2 == 0) ? 32'h01 : 32'h02);
      chk("limit_hold", 32'(bus.hold_cnt), 32'(c % 4));
    end
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("nolimit_gnt",  32'(bus.gnt),      32'h01);
      chk("nolimit_hold", 32'(bus.hold_cnt), 32'((c < 15) ? c : 15));
    end
`endif

    bus.req = 8'h00;
    tick();
    bus.req = 8'h20;
    tick();
    chk("pre_areset_gnt", 32'(bus.gnt), 32'h20);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_gnt",   32'(bus.gnt),   32'h00);
    chk("areset_sel",   32'(bus.sel),   32'h0);
    chk("areset_valid", 32'(bus.valid), 32'h0);
    #1 rst_n = 1'b1;
    bus.req = 8'h30;
    tick();
    chk("post_areset_gnt", 32'(bus.gnt), 32'h10);
    chk("post_areset_sel", 32'(bus.sel), 32'h4);

    r = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 5))
        0:       r = 8'($urandom);
        1, 2:    r = r;
        3:       r = r & ~bus.gnt;
        4:       r = r ^ (8'h01 << $urandom_range(0, 7));
        default: r = ($urandom_range(0, 3) == 0) ? 8'h00 : r | (8'h01 << $urandom_range(0, 7));
      endcase
      bus.req = r;
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    bus.req = 8'h00;
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
